// File: rtl/usb3_tx_scramble_skp_pkg.sv
// Shared definitions for the USB 3.0 TX scrambler / SKP scheduler:
// 8b/10b K-code constants, scrambler polynomial, default seed and scheduler states.
package usb3_tx_scramble_skp_pkg;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K_SKP = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K_COM = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  // x^16 + x^5 + x^4 + x^3 + 1, Galois feedback taps below the x^16 term
  localparam logic [15:0] LFSR_TAPS      = 16'h0039;
  localparam logic [15:0] SCRAM_SEED_DEF = 16'hFFFF;

  typedef enum logic {
    ST_PASS   = 1'b0,
    ST_INSERT = 1'b1
  } skp_state_e;

  function automatic logic is_legal_k(input logic [7:0] b);
    case (b)
      K28_0, K_SKP, K28_2, K28_3, K28_4, K_COM,
      K28_6, K28_7, K23_7, K27_7, K29_7, K30_7: is_legal_k = 1'b1;
      default:                                  is_legal_k = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/usb3_tx_scramble_skp_if.sv
// Raw (link-layer side) and processed (PIPE side) word bus of the TX scrambler.
// master = link layer / bench side, slave = the scrambler.
interface usb3_tx_scramble_skp_if #(
  parameter int NUM_BYTES = 4
);
  logic [NUM_BYTES-1:0]   raw_datak;
  logic [8*NUM_BYTES-1:0] raw_data;
  logic                   raw_active;
  logic                   raw_stall;
  logic [NUM_BYTES-1:0]   proc_datak;
  logic [8*NUM_BYTES-1:0] proc_data;
  logic                   proc_skp;

  modport master (
    output raw_datak, raw_data, raw_active,
    input  raw_stall, proc_datak, proc_data, proc_skp
  );

  modport slave (
    input  raw_datak, raw_data, raw_active,
    output raw_stall, proc_datak, proc_data, proc_skp
  );
endinterface

// File: rtl/usb3_tx_scramble_skp_lfsr_bytes.sv
// Combinational NUM_BYTES-byte scrambler LFSR: per-byte keys and the state after the word.
// COM bytes reload the seed, held (SKP) bytes leave the state untouched.
module usb3_lfsr_bytes
  import usb3_tx_scramble_skp_pkg::*;
#(
  parameter int          NUM_BYTES  = 4,
  parameter logic [15:0] SCRAM_SEED = SCRAM_SEED_DEF
) (
  input  logic [15:0]            state_i,
  input  logic [NUM_BYTES-1:0]   com_i,
  input  logic [NUM_BYTES-1:0]   hold_i,
  output logic [8*NUM_BYTES-1:0] key_o,
  output logic [15:0]            next_o
);

  logic [15:0] s;

  always_comb begin
    s     = state_i;
    key_o = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (com_i[i]) begin
        s = SCRAM_SEED;
      end else if (!hold_i[i]) begin
        // key bit b is the MSB before the b-th shift, LSB of the byte first
        for (int b = 0; b < 8; b++) begin
          key_o[8*i+b] = s[15];
          s = {s[14:0], 1'b0} ^ (s[15] ? LFSR_TAPS : 16'h0000);
        end
      end
    end
    next_o = s;
  end

endmodule

// File: rtl/usb3_tx_scramble_skp.sv
// USB 3.0 TX scrambler with SKP ordered-set scheduling and raw_stall backpressure.
// Two register stages: stage 1 scrambles or builds a SKP word, stage 2 drives the PIPE side.
module usb3_tx_scramble_skp
  import usb3_tx_scramble_skp_pkg::*;
#(
  parameter int          NUM_BYTES    = 4,
  parameter logic [15:0] SCRAM_SEED   = SCRAM_SEED_DEF,
  parameter int          SKP_INTERVAL = 354,
  parameter int          SKP_MAX_OWED = 4
) (
  input  logic                         local_clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         skp_inhibit,
  input  logic                         skp_defer,
  usb3_tx_scramble_skp_if.slave        bus,
  output logic                         err_undef,
  output logic                         skp_overflow
);

  localparam int HALF   = NUM_BYTES / 2;
  localparam int CRED_W = $clog2(SKP_INTERVAL + NUM_BYTES + 1);
  localparam int OWED_W = $clog2(SKP_MAX_OWED + 1);

  skp_state_e             fsm_q, fsm_d;
  logic                   raw_stall_q, raw_stall_d;
  logic [15:0]            lfsr_q, lfsr_d, lfsr_next;
  logic [CRED_W-1:0]      credit_q, credit_d, credit_sum;
  logic [OWED_W-1:0]      owed_q, owed_d;
  logic                   overflow_q, overflow_d;
  logic                   accrue, due, owed_inc;

  logic [8*NUM_BYTES-1:0] s1_data_q, s1_data_d;
  logic [NUM_BYTES-1:0]   s1_datak_q, s1_datak_d;
  logic                   s1_skp_q, s1_skp_d;
  logic                   s1_err_q, s1_err_d;

  logic [8*NUM_BYTES-1:0] proc_data_q;
  logic [NUM_BYTES-1:0]   proc_datak_q;
  logic                   proc_skp_q;
  logic                   err_undef_q;

  logic [NUM_BYTES-1:0]   com_vec, hold_vec;
  logic [8*NUM_BYTES-1:0] key;

  always_comb begin
    com_vec  = '0;
    hold_vec = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      com_vec[i]  = bus.raw_datak[i] && (bus.raw_data[8*i +: 8] == K_COM);
      hold_vec[i] = bus.raw_datak[i] && (bus.raw_data[8*i +: 8] == K_SKP);
    end
  end

  usb3_lfsr_bytes #(
    .NUM_BYTES  (NUM_BYTES),
    .SCRAM_SEED (SCRAM_SEED)
  ) u_lfsr (
    .state_i (lfsr_q),
    .com_i   (com_vec),
    .hold_i  (hold_vec),
    .key_o   (key),
    .next_o  (lfsr_next)
  );

  // Stage 1: SKP word while inserting, otherwise the accepted raw word (scrambled)
  always_comb begin
    s1_data_d  = '0;
    s1_datak_d = '0;
    s1_skp_d   = 1'b0;
    s1_err_d   = 1'b0;
    if (fsm_q == ST_INSERT) begin
      s1_data_d  = {NUM_BYTES{K_SKP}};
      s1_datak_d = '1;
      s1_skp_d   = 1'b1;
    end else begin
      s1_datak_d = bus.raw_datak;
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (bus.raw_datak[i]) begin
          s1_data_d[8*i +: 8] = bus.raw_data[8*i +: 8];
          if (!is_legal_k(bus.raw_data[8*i +: 8])) s1_err_d = 1'b1;
        end else begin
          s1_data_d[8*i +: 8] = enable ? (bus.raw_data[8*i +: 8] ^ key[8*i +: 8])
                                       : bus.raw_data[8*i +: 8];
        end
      end
    end
  end

  // Credit and owed-SKP bookkeeping; accrual only happens in PASS, decrement only in INSERT
  always_comb begin
    accrue     = !raw_stall_q && (fsm_q == ST_PASS);
    lfsr_d     = raw_stall_q ? lfsr_q : lfsr_next;
    credit_sum = credit_q + (accrue ? CRED_W'(NUM_BYTES) : '0);
    due        = (credit_sum >= CRED_W'(SKP_INTERVAL));
    credit_d   = due ? (credit_sum - CRED_W'(SKP_INTERVAL)) : credit_sum;
    owed_inc   = due && (owed_q != OWED_W'(SKP_MAX_OWED));
    overflow_d = overflow_q || (due && (owed_q == OWED_W'(SKP_MAX_OWED)));
    owed_d     = owed_q + OWED_W'(owed_inc)
                 - ((fsm_q == ST_INSERT) ? OWED_W'(HALF) : '0);
  end

  // Exit from INSERT looks at owed after this cycle's SKP word has been paid
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_PASS:
        if ((owed_q >= OWED_W'(HALF)) && !skp_inhibit && (!skp_defer || !bus.raw_active))
          fsm_d = ST_INSERT;
      ST_INSERT:
        if ((owed_d < OWED_W'(HALF)) || skp_inhibit || (skp_defer && bus.raw_active))
          fsm_d = ST_PASS;
      default: fsm_d = ST_PASS;
    endcase
    raw_stall_d = (fsm_d == ST_INSERT);
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q        <= ST_PASS;
      raw_stall_q  <= 1'b0;
      lfsr_q       <= SCRAM_SEED;
      credit_q     <= '0;
      owed_q       <= '0;
      overflow_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_datak_q   <= '0;
      s1_skp_q     <= 1'b0;
      s1_err_q     <= 1'b0;
      proc_data_q  <= '0;
      proc_datak_q <= '0;
      proc_skp_q   <= 1'b0;
      err_undef_q  <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      raw_stall_q  <= raw_stall_d;
      lfsr_q       <= lfsr_d;
      credit_q     <= credit_d;
      owed_q       <= owed_d;
      overflow_q   <= overflow_d;
      s1_data_q    <= s1_data_d;
      s1_datak_q   <= s1_datak_d;
      s1_skp_q     <= s1_skp_d;
      s1_err_q     <= s1_err_d;
      // Stage 2: PIPE-side output registers
      proc_data_q  <= s1_data_q;
      proc_datak_q <= s1_datak_q;
      proc_skp_q   <= s1_skp_q;
      err_undef_q  <= s1_err_q;
    end
  end

  assign bus.raw_stall  = raw_stall_q;
  assign bus.proc_data  = proc_data_q;
  assign bus.proc_datak = proc_datak_q;
  assign bus.proc_skp   = proc_skp_q;
  assign err_undef      = err_undef_q;
  assign skp_overflow   = overflow_q;

endmodule

// File: tb/tb_usb3_tx_scramble_skp.sv
// Scoreboard bench for usb3_tx_scramble_skp (NUM_BYTES=4, SKP_INTERVAL=354, SKP_MAX_OWED=4).
// A cycle model predicts raw_stall and the word that must appear on proc_* two edges later.
module tb_usb3_tx_scramble_skp;

  logic clk;
  logic rst_n;
  logic enable, skp_inhibit, skp_defer;
  logic err_undef, skp_overflow;

  usb3_tx_scramble_skp_if #(.NUM_BYTES(4)) bus ();

  usb3_tx_scramble_skp #(
    .NUM_BYTES    (4),
    .SCRAM_SEED   (16'hFFFF),
    .SKP_INTERVAL (354),
    .SKP_MAX_OWED (4)
  ) dut (
    .local_clk    (clk),
    .reset_n      (rst_n),
    .enable       (enable),
    .skp_inhibit  (skp_inhibit),
    .skp_defer    (skp_defer),
    .bus          (bus),
    .err_undef    (err_undef),
    .skp_overflow (skp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  bit          m_fsm;
  logic [15:0] m_lfsr;
  int          m_credit, m_owed;
  bit          m_ovf;
  logic [37:0] exp_q[$];

  // observation statistics
  int stall_cnt, skp_cnt, acc_cnt, err_cnt, first_stall_acc;

  logic [7:0] legal_tbl [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit legal_k(input logic [7:0] b);
    bit r = 1'b0;
    for (int j = 0; j < 12; j++) if (legal_tbl[j] == b) r = 1'b1;
    return r;
  endfunction

  function automatic logic [15:0] adv8(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int j = 0; j < 8; j++) r = r[15] ? ((r << 1) ^ 16'h0039) : (r << 1);
    return r;
  endfunction

  function automatic logic [7:0] key8(input logic [15:0] s);
    logic [15:0] r;
    logic [7:0]  k;
    r = s;
    for (int j = 0; j < 8; j++) begin
      k[j] = r[15];
      r = r[15] ? ((r << 1) ^ 16'h0039) : (r << 1);
    end
    return k;
  endfunction

  task automatic clr_stats();
    stall_cnt = 0; skp_cnt = 0; acc_cnt = 0; err_cnt = 0; first_stall_acc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b1; skp_inhibit = 1'b0; skp_defer = 1'b0;
    bus.raw_data = '0; bus.raw_datak = '0; bus.raw_active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_proc", 64'({bus.proc_skp, bus.proc_datak, bus.proc_data}), 64'd0);
    check("rst_raw_stall", 64'(bus.raw_stall), 64'd0);
    check("rst_err_undef", 64'(err_undef), 64'd0);
    check("rst_skp_overflow", 64'(skp_overflow), 64'd0);
    rst_n = 1'b1;
    m_fsm = 1'b0; m_lfsr = 16'hFFFF; m_credit = 0; m_owed = 0; m_ovf = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    clr_stats();
  endtask

  // Present one word for one clock; model predicts stall now and proc two edges later.
  task automatic cycle(input logic [31:0] d, input logic [3:0] k, input logic act);
    logic [37:0] e, got;
    logic [7:0]  b;
    int          sum, owed_n;
    bit          due;
    bus.raw_data = d; bus.raw_datak = k; bus.raw_active = act;
    check("raw_stall", 64'(bus.raw_stall), 64'(m_fsm));
    if (bus.raw_stall) stall_cnt++;
    else acc_cnt++;
    if (bus.raw_stall && first_stall_acc < 0) first_stall_acc = acc_cnt;
    e = '0;
    if (m_fsm) begin
      e = {1'b1, 1'b0, 4'hF, 32'h3C3C3C3C};
    end else begin
      e[35:32] = k;
      for (int i = 0; i < 4; i++) begin
        b = d[8*i +: 8];
        if (k[i]) begin
          e[8*i +: 8] = b;
          if (!legal_k(b)) e[36] = 1'b1;
          if (b == 8'hBC) m_lfsr = 16'hFFFF;
          else if (b != 8'h3C) m_lfsr = adv8(m_lfsr);
        end else begin
          e[8*i +: 8] = enable ? (b ^ key8(m_lfsr)) : b;
          m_lfsr = adv8(m_lfsr);
        end
      end
    end
    sum = m_credit + (m_fsm ? 0 : 4);
    due = (sum >= 354);
    m_credit = due ? sum - 354 : sum;
    owed_n = m_owed + ((due && m_owed < 4) ? 1 : 0) - (m_fsm ? 2 : 0);
    if (due && m_owed == 4) m_ovf = 1'b1;
    if (!m_fsm) m_fsm = (m_owed >= 2) && !skp_inhibit && (!skp_defer || !act);
    else        m_fsm = !((owed_n < 2) || skp_inhibit || (skp_defer && act));
    m_owed = owed_n;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {bus.proc_skp, err_undef, bus.proc_datak, bus.proc_data};
    if (exp_q.size() == 0) check("proc_queue", 64'(exp_q.size()), 64'd1);
    else check("proc", 64'(got), 64'(exp_q.pop_front()));
    if (bus.proc_skp) skp_cnt++;
    if (err_undef) err_cnt++;
    check("skp_overflow", 64'(skp_overflow), 64'(m_ovf));
  endtask

  initial begin
    rst_n = 1'b0;

    // COM reseeds; following D bytes take the first keys after FFFF; enable toggling
    do_reset();
    cycle(32'h000000BC, 4'b0001, 1'b1);
    for (int i = 0; i < 4; i++) cycle($urandom, 4'b0000, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) cycle($urandom, 4'b0000, 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) cycle($urandom, 4'b0000, 1'b1);

    // deferred SKP: nothing during the packet, owed=4 paid as 2 words once idle
    do_reset();
    skp_defer = 1'b1;
    for (int i = 0; i < 500; i++) cycle($urandom, 4'b0000, 1'b1);
    check("t3_skp_in_packet", 64'(skp_cnt), 64'd0);
    check("t3_stall_in_packet", 64'(stall_cnt), 64'd0);
    clr_stats();
    for (int i = 0; i < 20; i++) cycle($urandom, 4'b0000, 1'b0);
    check("t3_stall_cycles", 64'(stall_cnt), 64'd2);
    check("t3_skp_words", 64'(skp_cnt), 64'd2);

    // reset asserted mid-INSERT, without a clock edge
    do_reset();
    skp_defer = 1'b1;
    for (int i = 0; i < 500; i++) cycle($urandom, 4'b0000, 1'b1);
    cycle($urandom, 4'b0000, 1'b0);
    check("t6_in_insert", 64'(bus.raw_stall), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_proc", 64'({bus.proc_skp, bus.proc_datak, bus.proc_data}), 64'd0);
    check("t6_async_stall", 64'(bus.raw_stall), 64'd0);
    check("t6_async_flags", 64'({err_undef, skp_overflow}), 64'd0);
    do_reset();

    // D00 stream from a fresh reset: owed reaches 2 at word 177, SKP word follows word 178
    for (int i = 0; i < 400; i++) cycle(32'h00000000, 4'b0000, 1'b1);
    check("t2_first_stall_after", 64'(first_stall_acc), 64'd178);
    check("t2_stall_cycles", 64'(stall_cnt), 64'd2);
    check("t2_skp_words", 64'(skp_cnt), 64'd2);

    // inhibit: credit keeps accruing, 5th due with owed=4 sets overflow at word 443
    do_reset();
    skp_inhibit = 1'b1;
    for (int i = 0; i < 442; i++) cycle($urandom, 4'b0000, 1'b1);
    check("t4_ovf_before", 64'(skp_overflow), 64'd0);
    cycle($urandom, 4'b0000, 1'b1);
    check("t4_ovf_after", 64'(skp_overflow), 64'd1);
    for (int i = 0; i < 1557; i++) cycle($urandom, 4'b0000, 1'b1);
    check("t4_no_skp", 64'(skp_cnt), 64'd0);
    check("t4_no_stall", 64'(stall_cnt), 64'd0);
    clr_stats();
    skp_inhibit = 1'b0;
    for (int i = 0; i < 10; i++) cycle($urandom, 4'b0000, 1'b1);
    check("t4_release_skp", 64'(skp_cnt), 64'd2);
    check("t4_ovf_sticky", 64'(skp_overflow), 64'd1);

    // undefined K codes pulse err_undef; legal K words (including raw SKP bytes) do not
    do_reset();
    cycle(32'h11_22_00_55, 4'b0010, 1'b1);
    cycle($urandom, 4'b0000, 1'b1);
    cycle(32'hFE_F7_3C_1C, 4'b1111, 1'b1);
    cycle(32'hFB_FD_DC_FC, 4'b1111, 1'b1);
    cycle(32'hBD_5C_7C_9C, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) cycle($urandom, 4'b0000, 1'b1);
    check("t5_err_pulses", 64'(err_cnt), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
